// File: rtl/audio_pkg.sv
// Shared audio-path types and sizes for the I2S output stage.
package audio_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } tx_state_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: bclk toggles whenever div_cnt wraps; fall_stb is high in the
// cycle whose closing edge drives bclk low, so callers update in lockstep with it.
module i2s_bclk_gen #(
  parameter int CLK_DIV_HALF = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bclk,
  output logic fall_stb
);
  localparam int CW = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV_HALF - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  always_comb begin
    wrap      = run && (div_cnt_q == LAST);
    div_cnt_d = div_cnt_q + CW'(1);
    bclk_d    = bclk_q;
    if (!run) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (wrap) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk     = bclk_q;
  assign fall_stb = wrap && bclk_q;
endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo I2S transmitter: one sample per 32-slot frame, sent MSB-first in both channels.
// Define I2S_TX_LJ_EN for left-justified lrclk; otherwise standard I2S with a one-slot lead.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV_HALF = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] samp_in,
  output logic                samp_req,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                busy
);
  tx_state_t           state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d, slot_nxt;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                sdata_q, sdata_d;
  logic                lrclk_q, lrclk_d;
  logic                samp_req_q, samp_req_d;
  logic                fall_stb;

  function automatic logic lr_of(input logic [SLOT_W-1:0] k);
    logic [SLOT_W-1:0] k1;
    k1 = k + SLOT_W'(1);
`ifdef I2S_TX_LJ_EN
    return k[SLOT_W-1];
`else
    return k1[SLOT_W-1];
`endif
  endfunction

  i2s_bclk_gen #(.CLK_DIV_HALF(CLK_DIV_HALF)) u_bclk (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q != IDLE),
    .bclk     (bclk),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    hold_d     = hold_q;
    sdata_d    = sdata_q;
    lrclk_d    = lrclk_q;
    samp_req_d = 1'b0;
    slot_nxt   = slot_q + SLOT_W'(1);
    case (state_q)
      IDLE: begin
        if (en) begin
          // Priming slot: request the first sample one slot before its MSB is due.
          state_d    = RUN;
          slot_d     = SLOT_W'(FRAME_SLOTS - 1);
          samp_req_d = 1'b1;
          sdata_d    = 1'b0;
          lrclk_d    = lr_of(SLOT_W'(FRAME_SLOTS - 1));
        end
      end
      RUN: begin
        if (fall_stb) begin
          slot_d  = slot_nxt;
          lrclk_d = lr_of(slot_nxt);
          if (slot_nxt == '0) begin
            hold_d  = samp_in;
            sdata_d = samp_in[SAMPLE_W-1];
          end else begin
            sdata_d = hold_q[4'd15 - slot_nxt[3:0]];
          end
          if (slot_nxt == SLOT_W'(FRAME_SLOTS - 1)) begin
            if (en) samp_req_d = 1'b1;
            else    state_d    = STOP;
          end
        end
      end
      STOP: begin
        if (fall_stb) begin
          state_d = IDLE;
          slot_d  = '0;
          hold_d  = '0;
          sdata_d = 1'b0;
          lrclk_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      hold_q     <= '0;
      sdata_q    <= 1'b0;
      lrclk_q    <= 1'b0;
      samp_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      hold_q     <= hold_d;
      sdata_q    <= sdata_d;
      lrclk_q    <= lrclk_d;
      samp_req_q <= samp_req_d;
    end
  end

  assign samp_req = samp_req_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: arithmetic waveform model per cycle plus per-frame table checks.
module tb_i2s_tx;
  localparam int N    = 2;
  localparam int SLOT = 2 * N;
`ifdef I2S_TX_LJ_EN
  localparam logic [31:0] LR_EXP = 32'h0000FFFF;
`else
  localparam logic [31:0] LR_EXP = 32'h0001FFFE;
`endif

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] samp_in;
  logic        samp_req, bclk, lrclk, sdata, busy;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sent[$];

  typedef struct {
    logic [15:0] samp;
    logic [31:0] bits;
    logic [31:0] lr;
  } vec_t;
  vec_t tab[3];

  i2s_tx #(.CLK_DIV_HALF(N)) dut (
    .clk(clk), .rst(rst), .en(en), .samp_in(samp_in), .samp_req(samp_req),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " bclk"}, 32'(bclk), 32'd0);
    check({tag, " lrclk"}, 32'(lrclk), 32'd0);
    check({tag, " sdata"}, 32'(sdata), 32'd0);
    check({tag, " samp_req"}, 32'(samp_req), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  function automatic logic exp_lr(input int k);
`ifdef I2S_TX_LJ_EN
    return k >= 16;
`else
    return ((k + 1) % 32) >= 16;
`endif
  endfunction

  // t counts cycles from the first RUN cycle; slot index 0 is the priming slot.
  task automatic expect_at(input int t, input int nfr,
                           output logic eb, output logic el, output logic ed,
                           output logic er, output logic ey);
    int s, ph, k, f;
    s = t / SLOT;
    ph = t % SLOT;
    eb = 0; el = 0; ed = 0; er = 0; ey = 0;
    if (t < (32 * nfr + 1) * SLOT) begin
      ey = 1;
      eb = (ph >= N);
      er = (ph == 0) && (s % 32 == 0) && (s < 32 * nfr);
      if (s == 0) begin
        k = 31;
      end else begin
        k = (s - 1) % 32;
        f = (s - 1) / 32;
        ed = sent[f][15 - (k % 16)];
      end
      el = exp_lr(k);
    end
  endtask

  task automatic run_seq(input int nfr, input int ntab, input int abort_s);
    logic        eb, el, ed, er, ey;
    logic [31:0] wbits, wlr;
    int          s, ph, k, f, t_end, t_max;
    bit          present;
    sent.delete();
    present = 0;
    wbits = '0;
    wlr = '0;
    en = 1'b1;
    t_end = (32 * nfr + 1) * SLOT;
    t_max = (abort_s >= 0) ? abort_s * SLOT : t_end + 3 * SLOT;
    tick();
    for (int t = 0; t <= t_max; t++) begin
      if (t > 0) tick();
      s = t / SLOT;
      ph = t % SLOT;
      if (present) begin
        f = sent.size();
        samp_in = (f < ntab) ? tab[f].samp : 16'($urandom);
        sent.push_back(samp_in);
        present = 0;
      end
      expect_at(t, nfr, eb, el, ed, er, ey);
      check("bclk", 32'(bclk), 32'(eb));
      check("lrclk", 32'(lrclk), 32'(el));
      check("sdata", 32'(sdata), 32'(ed));
      check("samp_req", 32'(samp_req), 32'(er));
      check("busy", 32'(busy), 32'(ey));
      if (ey && s >= 1 && ph == N) begin
        k = (s - 1) % 32;
        f = (s - 1) / 32;
        wbits[31 - k] = sdata;
        wlr[31 - k] = lrclk;
        if (k == 31 && f < ntab) begin
          check("frame bits", wbits, tab[f].bits);
          check("frame lrclk", wlr, tab[f].lr);
        end
      end
      if (er) present = 1;
      if (s % 32 == 1 && ph == 0) samp_in = 16'($urandom);
      if (s == 32 * (nfr - 1) + 6 && ph == 0) en = 1'b0;
      if (abort_s < 0 && t == t_end - SLOT + 1) en = 1'b1;
      if (abort_s < 0 && t == t_end - SLOT + 2) en = 1'b0;
      if (abort_s >= 0 && t == t_max) rst = 1'b0;
    end
    if (abort_s >= 0) begin
      tick();
      check_idle("mid-frame reset");
      tick();
      check_idle("reset held");
      rst = 1'b1;
      en = 1'b0;
      tick();
      check_idle("after reset release");
    end
  endtask

  initial begin
    tab[0] = '{16'hA5C3, 32'hA5C3A5C3, LR_EXP};
    tab[1] = '{16'h8000, 32'h80008000, LR_EXP};
    tab[2] = '{16'h7FFF, 32'h7FFF7FFF, LR_EXP};
    rst = 1'b0;
    en = 1'b0;
    samp_in = '0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("idle en=0");
    end
    // Table frames, then random frames, en dropped in the last frame.
    run_seq(5, 3, -1);
    // Reset asserted at frame slot 20 (slot index 21 counting the priming slot).
    run_seq(100, 0, 21);
    // Clean restart after reset, including the table pattern again.
    run_seq(3, 1, -1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
